// File: rtl/timer_service_master_if.sv
// Avalon-MM bus between timer_service_master and the interval timer's 16-bit s1 port.
interface timer_service_master_if;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata;
    logic        timer_irq;

    modport master (
        output av_address,
        output av_chipselect,
        output av_write_n,
        output av_writedata,
        input  av_readdata,
        input  timer_irq
    );

    modport slave (
        input  av_address,
        input  av_chipselect,
        input  av_write_n,
        input  av_writedata,
        output av_readdata,
        output timer_irq
    );
endinterface

// File: rtl/timer_service_master.sv
// timer_service_master: Avalon-MM initiator that programs, runs, clears and
// stops the interval timer, counts serviced timeouts, and optionally reads a
// 32-bit counter snapshot.
// Optional feature macro: TIMER_SERVICE_SNAPSHOT_EN (snapshot path present
// when defined; otherwise snap_req is ignored and snap outputs stay 0).
module timer_service_master #(
    parameter int TICK_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  snap_req,
    input  logic [31:0]           cfg_period,
    input  logic                  cfg_continuous,
    output logic                  busy,
    output logic                  tick,
    output logic [TICK_W-1:0]     tick_count,
    output logic [31:0]           snap_value,
    output logic                  snap_valid,
    timer_service_master_if.master bus
);

`ifdef TIMER_SERVICE_SNAPSHOT_EN
    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR, STP, SNW, SNL, SNH, SNC
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR, STP
    } state_t;
`endif

    state_t      state;
    state_t      next_state;
    logic        stop_pend;
    logic [15:0] period_hi;
    logic        cont_q;

    // Bus values for the cycle after this edge, decoded from next_state so
    // every bus output can be registered without adding latency.
    logic [2:0]  addr_d;
    logic        cs_d;
    logic        wn_d;
    logic [15:0] wd_d;

`ifdef TIMER_SERVICE_SNAPSHOT_EN
    logic        snap_pend;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state selection and bus decode of the upcoming state
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = WR_PL;
            WR_PL:   next_state = WR_PH;
            WR_PH:   next_state = WR_CTRL;
            WR_CTRL: next_state = RUN;
            RUN: begin
                if (bus.timer_irq)  next_state = CLR;
                else if (stop_pend) next_state = STP;
`ifdef TIMER_SERVICE_SNAPSHOT_EN
                else if (snap_pend) next_state = SNW;
`endif
            end
            CLR:     next_state = cont_q ? RUN : IDLE;
            STP:     next_state = IDLE;
`ifdef TIMER_SERVICE_SNAPSHOT_EN
            SNW:     next_state = SNL;
            SNL:     next_state = SNH;
            SNH:     next_state = SNC;
            SNC:     next_state = RUN;
`endif
            default: next_state = IDLE;
        endcase

        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = 3'd0;
        wd_d   = 16'h0000;
        case (next_state)
            // WR_PL is only entered from IDLE on start, so the live input is current
            WR_PL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = cfg_period[15:0]; end
            WR_PH:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = period_hi; end
            WR_CTRL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = {12'h000, 1'b0, 1'b1, cont_q, 1'b1}; end
            CLR:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; end
            STP:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0008; end
`ifdef TIMER_SERVICE_SNAPSHOT_EN
            SNW:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4; end
            SNL:     begin cs_d = 1'b1; addr_d = 3'd4; end
            SNH:     begin cs_d = 1'b1; addr_d = 3'd5; end
`endif
            default: ;
        endcase
    end

    // Registered outputs, tick counter and sticky stop request
    always_ff @(posedge clk) begin
        if (reset) begin
            busy              <= 1'b0;
            tick              <= 1'b0;
            tick_count        <= '0;
            bus.av_chipselect <= 1'b0;
            bus.av_write_n    <= 1'b1;
            bus.av_address    <= 3'd0;
            bus.av_writedata  <= 16'h0000;
            stop_pend         <= 1'b0;
        end else begin
            busy              <= (next_state != IDLE);
            tick              <= (next_state == CLR);
            if (next_state == CLR) tick_count <= tick_count + TICK_W'(1);
            bus.av_chipselect <= cs_d;
            bus.av_write_n    <= wn_d;
            bus.av_address    <= addr_d;
            bus.av_writedata  <= wd_d;
            // Entering IDLE (including one-shot CLR->IDLE) drops a pending stop
            if (next_state == IDLE || next_state == STP) stop_pend <= 1'b0;
            else if (stop && state != IDLE)              stop_pend <= 1'b1;
        end
    end

    // Configuration captured once per accepted start; ignored while busy
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            period_hi <= cfg_period[31:16];
            cont_q    <= cfg_continuous;
        end
    end

`ifdef TIMER_SERVICE_SNAPSHOT_EN
    logic [15:0] snap_lo;
    logic [31:0] snap_q;
    logic        snap_valid_q;

    // Sticky snapshot request and snapshot valid pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_pend    <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_q       <= 32'h0;
        end else begin
            snap_valid_q <= (next_state == SNC);
            if (state == SNC) snap_q <= {bus.av_readdata, snap_lo};
            if (next_state == IDLE || next_state == SNW) snap_pend <= 1'b0;
            else if (snap_req && state != IDLE)          snap_pend <= 1'b1;
        end
    end

    // Low half arrives in SNH, one cycle after address 4 was presented
    always_ff @(posedge clk) begin
        if (state == SNH) snap_lo <= bus.av_readdata;
    end

    // The high half is on the read bus during SNC itself, so it is forwarded
    // for that cycle and held from the register afterwards.
    assign snap_valid = snap_valid_q;
    assign snap_value = snap_valid_q ? {bus.av_readdata, snap_lo} : snap_q;
`else
    logic unused_snap;
    assign unused_snap = snap_req ^ (^bus.av_readdata);
    assign snap_valid  = 1'b0;
    assign snap_value  = 32'h0;
`endif

endmodule

// File: tb/tb_timer_service_master.sv
// Self-checking bench for timer_service_master: a scoreboard of expected bus
// accesses plus per-scenario tasks with inline checks.
module tb_timer_service_master;
    localparam int TICK_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              snap_req = 1'b0;
    logic [31:0]       cfg_period = 32'h0;
    logic              cfg_continuous = 1'b0;
    logic              busy;
    logic              tick;
    logic [TICK_W-1:0] tick_count;
    logic [31:0]       snap_value;
    logic              snap_valid;

    int n_cmp = 0;
    int n_err = 0;

    // {is_write, address, writedata}
    logic [19:0] exp_q[$];

    timer_service_master_if bus();

    timer_service_master #(.TICK_W(TICK_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .snap_req(snap_req),
        .cfg_period(cfg_period), .cfg_continuous(cfg_continuous),
        .busy(busy), .tick(tick), .tick_count(tick_count),
        .snap_value(snap_value), .snap_valid(snap_valid), .bus(bus)
    );

    always #5 clk = ~clk;

    // Timer model: registered read data, valid the cycle after the address
    initial bus.av_readdata = 16'h0;
    initial bus.timer_irq = 1'b0;
    always @(posedge clk) begin
        if (bus.av_chipselect === 1'b1 && bus.av_write_n === 1'b1)
            bus.av_readdata <= (bus.av_address == 3'd4) ? 16'h1234 :
                               (bus.av_address == 3'd5) ? 16'hABCD : 16'h0000;
    end

    // Bus monitor: every access must match the head of the scoreboard
    always @(negedge clk) begin
        logic [19:0] got;
        logic [19:0] exp;
        if (bus.av_chipselect === 1'b1) begin
            got = {~bus.av_write_n, bus.av_address, bus.av_writedata};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL bus_unexpected: got w=%0b addr=%0d data=%h, required no access",
                         got[19], got[18:16], got[15:0]);
            end else begin
                exp = exp_q.pop_front();
                if (got[19:16] !== exp[19:16] || (exp[19] && got[15:0] !== exp[15:0])) begin
                    n_err++;
                    $display("FAIL bus_access: got w=%0b addr=%0d data=%h, required w=%0b addr=%0d data=%h",
                             got[19], got[18:16], got[15:0], exp[19], exp[18:16], exp[15:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic [31:0] period, input logic cont);
        @(posedge clk); #1;
        start = 1'b1; cfg_period = period; cfg_continuous = cont;
        @(posedge clk); #1;
        start = 1'b0; cfg_period = 32'hDEAD_BEEF; cfg_continuous = ~cont;
    endtask

    task automatic push_prog(input logic [31:0] period, input logic cont);
        exp_q.push_back({1'b1, 3'd2, period[15:0]});
        exp_q.push_back({1'b1, 3'd3, period[31:16]});
        exp_q.push_back({1'b1, 3'd1, 16'h0005 | {14'h0, cont, 1'b0}});
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected bus accesses not seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL rst_tick: got %b, required 0", tick); end
        n_cmp++; if (snap_valid !== 1'b0) begin n_err++; $display("FAIL rst_snap_valid: got %b, required 0", snap_valid); end
        n_cmp++; if (tick_count !== '0) begin n_err++; $display("FAIL rst_tick_count: got %0d, required 0", tick_count); end
        n_cmp++; if (snap_value !== 32'h0) begin n_err++; $display("FAIL rst_snap_value: got %h, required 0", snap_value); end
        n_cmp++; if (bus.av_chipselect !== 1'b0) begin n_err++; $display("FAIL rst_cs: got %b, required 0", bus.av_chipselect); end
        n_cmp++; if (bus.av_write_n !== 1'b1) begin n_err++; $display("FAIL rst_write_n: got %b, required 1", bus.av_write_n); end
        n_cmp++; if (bus.av_address !== 3'd0) begin n_err++; $display("FAIL rst_addr: got %0d, required 0", bus.av_address); end
        n_cmp++; if (bus.av_writedata !== 16'h0) begin n_err++; $display("FAIL rst_wdata: got %h, required 0", bus.av_writedata); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_start_cont;
        push_prog(32'h0001_86A0, 1'b1);
        @(posedge clk); #1;
        start = 1'b1; cfg_period = 32'h0001_86A0; cfg_continuous = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL start_busy_c0: got %b, required 0", busy); end
        @(posedge clk); #1;
        start = 1'b0; cfg_period = 32'hDEAD_BEEF; cfg_continuous = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_busy_c1: got %b, required 1", busy); end
        repeat (4) @(negedge clk);
        check_drained("start_writes");
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_busy: got %b, required 1", busy); end
    endtask

    task automatic test_ticks;
        bit found;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back({1'b1, 3'd0, 16'h0000});
            @(posedge clk); #1;
            bus.timer_irq = 1'b1;
            found = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                @(negedge clk);
                if (tick === 1'b1) found = 1'b1;
            end
            n_cmp++;
            if (!found) begin n_err++; $display("FAIL tick_timeout: got no tick, required tick %0d", k); end
            else if (tick_count !== TICK_W'(k)) begin n_err++; $display("FAIL tick_count: got %0d, required %0d", tick_count, k); end
            @(posedge clk); #1;
            bus.timer_irq = 1'b0;
            @(negedge clk);
            n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL tick_width: got %b, required 0", tick); end
            repeat (2) @(negedge clk);
        end
        check_drained("tick_clears");
    endtask

    task automatic test_stop_with_irq;
        bit found;
        exp_q.push_back({1'b1, 3'd0, 16'h0000});
        exp_q.push_back({1'b1, 3'd1, 16'h0008});
        @(posedge clk); #1;
        bus.timer_irq = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            @(negedge clk);
            if (tick === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL stopirq_tick: got no tick, required one"); end
        @(posedge clk); #1;
        bus.timer_irq = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (busy === 1'b0) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL stopirq_idle: got busy=%b, required 0", busy); end
        n_cmp++; if (tick_count !== TICK_W'(4)) begin n_err++; $display("FAIL stopirq_count: got %0d, required 4", tick_count); end
        check_drained("stopirq_writes");
    endtask

    task automatic test_oneshot;
        bit found;
        push_prog(32'h0000_0010, 1'b0);
        pulse_start(32'h0000_0010, 1'b0);
        repeat (5) @(negedge clk);
        check_drained("oneshot_prog");
        exp_q.push_back({1'b1, 3'd0, 16'h0000});
        @(posedge clk); #1;
        bus.timer_irq = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            @(negedge clk);
            if (tick === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL oneshot_tick: got no tick, required one"); end
        else if (tick_count !== TICK_W'(5)) begin n_err++; $display("FAIL oneshot_count: got %0d, required 5", tick_count); end
        @(posedge clk); #1;
        bus.timer_irq = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL oneshot_idle: got busy=%b, required 0", busy); end
        repeat (4) @(negedge clk);
        check_drained("oneshot_clear");
    endtask

    task automatic test_snapshot;
        bit found;
        int nvalid;
        push_prog(32'h0000_1000, 1'b1);
        pulse_start(32'h0000_1000, 1'b1);
        repeat (5) @(negedge clk);
        check_drained("snap_prog");
`ifdef TIMER_SERVICE_SNAPSHOT_EN
        exp_q.push_back({1'b1, 3'd4, 16'h0000});
        exp_q.push_back({1'b0, 3'd4, 16'h0000});
        exp_q.push_back({1'b0, 3'd5, 16'h0000});
        @(posedge clk); #1;
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            @(negedge clk);
            if (snap_valid === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL snap_timeout: got no snap_valid, required one"); end
        else if (snap_value !== 32'hABCD_1234) begin n_err++; $display("FAIL snap_value: got %h, required abcd1234", snap_value); end
        @(negedge clk);
        n_cmp++; if (snap_valid !== 1'b0) begin n_err++; $display("FAIL snap_valid_width: got %b, required 0", snap_valid); end
        n_cmp++; if (snap_value !== 32'hABCD_1234) begin n_err++; $display("FAIL snap_hold: got %h, required abcd1234", snap_value); end
`else
        @(posedge clk); #1;
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (snap_valid !== 1'b0) nvalid++;
        end
        n_cmp++; if (nvalid != 0) begin n_err++; $display("FAIL snap_disabled_valid: got %0d pulses, required 0", nvalid); end
        n_cmp++; if (snap_value !== 32'h0) begin n_err++; $display("FAIL snap_disabled_value: got %h, required 0", snap_value); end
`endif
        check_drained("snap_bus");
        exp_q.push_back({1'b1, 3'd1, 16'h0008});
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (busy === 1'b0) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL stop_idle: got busy=%b, required 0", busy); end
        check_drained("stop_write");
    endtask

    task automatic test_reset_mid;
        exp_q.push_back({1'b1, 3'd2, 16'h5678});
        exp_q.push_back({1'b1, 3'd3, 16'h1234});
        @(posedge clk); #1;
        start = 1'b1; cfg_period = 32'h1234_5678; cfg_continuous = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.av_chipselect !== 1'b0) begin n_err++; $display("FAIL rstmid_cs: got %b, required 0", bus.av_chipselect); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
        n_cmp++; if (tick_count !== '0) begin n_err++; $display("FAIL rstmid_count: got %0d, required 0", tick_count); end
        repeat (8) @(negedge clk);
        check_drained("rstmid_writes");
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_stay_idle: got %b, required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_start_cont();
        test_ticks();
        test_stop_with_irq();
        test_oneshot();
        test_snapshot();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/timer_service_master.md
# timer_service_master

Avalon-MM initiator that owns the interval timer's 16-bit `s1` slave port. It programs the 32-bit period, starts and stops the timer, clears each timeout, and counts ticks. It can also take a counter snapshot on request. It sits between fabric-side control logic and the timer, so hardware can use the timer without a Nios core servicing it.

## Interface
Parameters:
- `TICK_W`, 16: width of the tick counter.

Ports:
- `clk`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse; begins programming and running.
- `stop`  in  1: one-cycle pulse; stops the timer.
- `snap_req`  in  1: one-cycle pulse; requests a counter snapshot.
- `cfg_period`  in  32: period value, sampled on accepted `start`.
- `cfg_continuous`  in  1: continuous mode, sampled on accepted `start`.
- `busy`  out  1: high in every state except IDLE.
- `tick`  out  1: one-cycle pulse per serviced timeout.
- `tick_count`  out  TICK_W: number of serviced timeouts.
- `snap_value`  out  32: last captured snapshot.
- `snap_valid`  out  1: one-cycle pulse when `snap_value` updates.
- `av_address`  out  3: timer register index.
- `av_chipselect`  out  1: bus access strobe.
- `av_write_n`  out  1: active-low write.
- `av_writedata`  out  16: write data.
- `av_readdata`  in  16: timer read data.
- `timer_irq`  in  1: timer interrupt, level-sensitive.

## Operation
- Timer map: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- Control bits: [0] ITO, [1] CONT, [2] START, [3] STOP.
- Every bus access lasts one cycle. There is no waitrequest.
- Reads are `av_chipselect`=1 with `av_write_n`=1. `av_readdata` is valid the cycle after the address is presented.
- States and transitions:
  - IDLE → WR_PL on `start`.
  - WR_PL: writes `cfg_period[15:0]` to address 2.
  - WR_PH: writes `cfg_period[31:16]` to address 3.
  - WR_CTRL: writes `{12'b0,0,1,cont,1}` to address 1 (0x5 or 0x7) → RUN.
  - RUN: no bus access.
  - CLR: writes 0 to address 0, pulses `tick`, increments `tick_count`.
    - → IDLE if one-shot, else → RUN.
  - STP: writes 0x8 to address 1 → IDLE.
  - SNW: writes 0 to address 4.
  - SNL: reads address 4.
  - SNH: reads address 5 and captures the low half.
  - SNC: captures the high half, pulses `snap_valid` → RUN.
- RUN priority: `timer_irq` → CLR, then stop pending → STP, then snap pending → SNW.
- `stop` and `snap_req` arriving in any busy state set sticky pending flags. Each flag clears when its sequence starts. Both are ignored in IDLE.
- `start` while busy is ignored, and `cfg_*` are not resampled.
- `tick_count` wraps from 2^TICK_W−1 to 0. It is cleared only by `reset`.
- An irq and a stop in the same cycle: the tick is serviced first, then STP.
- In one-shot mode, a pending stop is dropped on the CLR→IDLE transition.
- Reset mid-sequence: the block returns to IDLE, the bus goes idle, and pending flags clear. Timer state is untouched.

## Timing
- Reset values:
  - `busy`, `tick`, `snap_valid`: 0.
  - `tick_count`: 0; `snap_value`: 0.
  - `av_chipselect`: 0; `av_write_n`: 1.
  - `av_address`: 0; `av_writedata`: 0.
- All outputs are registered.
- `start` sampled at cycle 0 gives bus writes in cycles 1, 2 and 3. RUN is entered at cycle 4.
- `timer_irq` high at cycle N gives the CLR write in cycle N+1, with `tick` high in N+1. `timer_irq` is low from N+2, so there is no double count.
- SNW in cycle M gives reads in M+1 and M+2. `snap_valid` and `snap_value` are valid in M+3.
- STP write in cycle K: `busy` falls at K+1.
- Bus outputs outside write/read states: `av_chipselect`=0, `av_write_n`=1.

## Configuration
- `TIMER_SERVICE_SNAPSHOT_EN` defined: snapshot path present as specified.
- Undefined:
  - The SNW/SNL/SNH/SNC states are absent.
  - `snap_req` is ignored.
  - `snap_value` is held at 0 and `snap_valid` at 0.

## Test plan
- Reset, then `start` with `cfg_period`=0x0001_86A0 and continuous=1:
  - Writes in order: (2,0x86A0), (3,0x0001), (1,0x0007).
  - `busy`=1 from cycle 1.
- In RUN, hold `timer_irq` high until the clear write:
  - Exactly one address-0 write per timeout; `tick` pulses once.
  - After 3 timeouts, `tick_count`=3.
- One-shot (continuous=0):
  - Control write 0x0005.
  - First timeout gives the clear write, then IDLE with `busy`=0.
- `stop` asserted the same cycle as `timer_irq`:
  - Clear write, then (1,0x0008), then IDLE; `tick_count`+1.
- Snapshot with timer model readdata 0x1234 at address 4 and 0xABCD at address 5:
  - `snap_value`=0xABCD_1234 with a one-cycle `snap_valid`.
  - Without the macro, there is no bus activity and `snap_valid` stays 0.
- `reset` pulsed during WR_PH:
  - Next cycle: `av_chipselect`=0 and `busy`=0.
  - `tick_count` is 0 and no further writes occur.
